// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_pkg
// Description : Shared defaults, colour type and collector state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_pkg;

    localparam int c_PIXEL_DATA_WIDTH = 10;
    localparam int c_SCREEN_WIDTH     = 640;
    localparam int c_SCREEN_HEIGHT    = 480;
    localparam int c_NUM_ENGINES      = 12;
    localparam int c_COLOUR_WIDTH     = 24;

    typedef logic [c_COLOUR_WIDTH-1:0] colour_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } coll_state_t;

    // Index width for an N-entry buffer, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : x/y raster position with start-of-frame and end-of-line flags.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import pixel_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = c_PIXEL_DATA_WIDTH,
    parameter int SCREEN_WIDTH     = c_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT    = c_SCREEN_HEIGHT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    output logic [PIXEL_DATA_WIDTH-1:0] x,
    output logic [PIXEL_DATA_WIDTH-1:0] y,
    output logic                        sof,
    output logic                        eol
);

    localparam logic [PIXEL_DATA_WIDTH-1:0] c_X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] c_Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);

    logic [PIXEL_DATA_WIDTH-1:0] r_x;
    logic [PIXEL_DATA_WIDTH-1:0] r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (en) begin
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign x   = r_x;
    assign y   = r_y;
    assign sof = (r_x == '0) && (r_y == '0);
    assign eol = (r_x == c_X_LAST);

endmodule
`default_nettype wire

// File: rtl/collectorn.sv
`default_nettype none
// ============================================================================
// Module      : collectorn
// Description : Captures N engine results per batch and serialises them into
//               a one-pixel-per-cycle valid/ready stream with sof/eol.
// Revision    : 1.0 - initial release
// ============================================================================
module collectorn
    import pixel_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = c_PIXEL_DATA_WIDTH,
    parameter int SCREEN_WIDTH     = c_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT    = c_SCREEN_HEIGHT,
    parameter int NUM_ENGINES      = c_NUM_ENGINES,
    parameter int COLOUR_WIDTH     = c_COLOUR_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    input  logic [NUM_ENGINES-1:0][COLOUR_WIDTH-1:0] in_data,
    output logic                                    fin_flag,
    output logic [COLOUR_WIDTH-1:0]                 out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    out_sof,
    output logic                                    out_eol
);

    localparam int                c_IDX_W = idx_width(NUM_ENGINES);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_ENGINES - 1);

    coll_state_t                            r_state;
    coll_state_t                            w_state_nxt;
    logic [c_IDX_W-1:0]                     r_idx;
    logic [c_IDX_W-1:0]                     w_idx_nxt;
    logic [NUM_ENGINES-1:0][COLOUR_WIDTH-1:0] r_buf;

    logic                                   w_in_ready;
    logic                                   w_capture;
    logic                                   w_out_hs;
    logic [PIXEL_DATA_WIDTH-1:0]            w_x;
    logic [PIXEL_DATA_WIDTH-1:0]            w_y;
    logic                                   w_unused;

    // Accepting the next batch on the last handshake keeps the stream bubble-free.
    assign w_in_ready = (r_state == EMPTY) ||
                        ((r_state == DRAIN) && (r_idx == c_LAST) && out_ready);
    assign w_capture  = in_valid && w_in_ready;
    assign w_out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (w_capture) begin
            w_state_nxt = DRAIN;
            w_idx_nxt   = '0;
        end else if (w_out_hs) begin
            if (r_idx == c_LAST) begin
                w_state_nxt = EMPTY;
            end else begin
                w_idx_nxt = r_idx + 1'b1;
            end
        end
    end

    // Buffer contents are irrelevant outside DRAIN, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= in_data;
        end
    end

    assign fin_flag  = w_capture;
    assign out_valid = (r_state == DRAIN);
    assign out_data  = out_valid ? r_buf[r_idx] : '0;

    raster_counter #(
        .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH),
        .SCREEN_WIDTH     (SCREEN_WIDTH),
        .SCREEN_HEIGHT    (SCREEN_HEIGHT)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .en    (w_out_hs),
        .x     (w_x),
        .y     (w_y),
        .sof   (out_sof),
        .eol   (out_eol)
    );

    // Position itself is not exported from this block.
    assign w_unused = ^{w_x, w_y};

endmodule
`default_nettype wire

// File: tb/tb_collectorn.sv
`default_nettype none
// ============================================================================
// Module      : tb_collectorn
// Description : Directed self-checking bench for collectorn (8x4 screen, N=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collectorn;

    localparam int c_CW = 24;
    localparam int c_N  = 3;

    logic                      clk;
    logic                      reset;
    logic                      in_valid;
    logic [c_N-1:0][c_CW-1:0]  in_data;
    logic                      fin_flag;
    logic [c_CW-1:0]           out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_sof;
    logic                      out_eol;

    int n_checks = 0;
    int n_fail   = 0;

    logic [27:0] obs;
    logic [27:0] exp_v;

    collectorn #(
        .PIXEL_DATA_WIDTH (10),
        .SCREEN_WIDTH     (8),
        .SCREEN_HEIGHT    (4),
        .NUM_ENGINES      (c_N),
        .COLOUR_WIDTH     (c_CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .fin_flag  (fin_flag),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {valid, sof, eol, fin, data}.
    function automatic logic [27:0] snap();
        return {out_valid, out_sof, out_eol, fin_flag, out_data};
    endfunction

    function automatic logic [27:0] mk(input logic v, input logic s, input logic e,
                                       input logic f, input logic [23:0] d);
        return {v, s, e, f, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) step();
        obs = snap(); exp_v = mk(0, 1, 0, 0, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_held obs=%h exp=%h", obs, exp_v); end
        reset = 1'b1;
        step();
        obs = snap(); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL reset_released obs=%h exp=%h", obs, exp_v); end
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (fin_flag !== 1'b1) begin n_fail++; $display("FAIL reset_fin_comb obs=%b exp=1", fin_flag); end
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (fin_flag !== 1'b0) begin n_fail++; $display("FAIL reset_fin_drop obs=%b exp=0", fin_flag); end
    endtask

    task automatic test_one_batch();
        logic [23:0] exp_d [3];
        exp_d = '{24'h11, 24'h22, 24'h33};
        in_data = {24'h33, 24'h22, 24'h11};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        obs = snap(); exp_v = mk(0, 1, 0, 1, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL batch_capture obs=%h exp=%h", obs, exp_v); end
        step();
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            obs = snap(); exp_v = mk(1, (i == 0), 0, 0, exp_d[i]); n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL batch_pix%0d obs=%h exp=%h", i, obs, exp_v); end
            step();
        end
        obs = snap(); exp_v = mk(0, 0, 0, 0, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL batch_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    // Pixels land at x=3,4,5; the next batch is offered while stalled.
    task automatic test_backpressure();
        in_data = {24'h33, 24'h22, 24'h11};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (fin_flag !== 1'b1) begin n_fail++; $display("FAIL bp_capture obs=%b exp=1", fin_flag); end
        step();
        in_data = {24'h66, 24'h55, 24'h44};
        obs = snap(); exp_v = mk(1, 0, 0, 0, 24'h11); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_pix0 obs=%h exp=%h", obs, exp_v); end
        step();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            obs = snap(); exp_v = mk(1, 0, 0, 0, 24'h22); n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL bp_stall%0d obs=%h exp=%h", c, obs, exp_v); end
            step();
        end
        out_ready = 1'b1;
        #1;
        obs = snap(); exp_v = mk(1, 0, 0, 0, 24'h22); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_resume obs=%h exp=%h", obs, exp_v); end
        step();
        obs = snap(); exp_v = mk(1, 0, 0, 1, 24'h33); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL bp_last obs=%h exp=%h", obs, exp_v); end
        step();
        in_valid = 1'b0;
    endtask

    // Third batch occupies x=6,7 of line 0 and x=0 of line 1.
    task automatic test_line_straddle();
        logic [23:0] exp_d [3];
        logic        exp_e [3];
        exp_d = '{24'h44, 24'h55, 24'h66};
        exp_e = '{1'b0, 1'b1, 1'b0};
        #1;
        for (int i = 0; i < 3; i++) begin
            obs = snap(); exp_v = mk(1, 0, exp_e[i], 0, exp_d[i]); n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL straddle_pix%0d obs=%h exp=%h", i, obs, exp_v); end
            step();
        end
        obs = snap(); exp_v = mk(0, 0, 0, 0, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL straddle_idle obs=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        int batch;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        batch = 0;
        for (int i = 0; i < c_N; i++) in_data[i] = 24'h100 + 24'(3 * batch + i);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (fin_flag !== 1'b1) begin n_fail++; $display("FAIL stream_first_fin obs=%b exp=1", fin_flag); end
        step();
        batch = 1;
        for (int i = 0; i < c_N; i++) in_data[i] = 24'h100 + 24'(3 * batch + i);
        for (int p = 0; p < 40; p++) begin
            #1;
            obs = snap();
            exp_v = mk(1, (p % 32 == 0), (p % 8 == 7), (p % 3 == 2), 24'h100 + 24'(p));
            n_checks++;
            if (obs !== exp_v) begin n_fail++; $display("FAIL stream_pix%0d obs=%h exp=%h", p, obs, exp_v); end
            step();
            if (p % 3 == 2) begin
                batch++;
                for (int i = 0; i < c_N; i++) in_data[i] = 24'h100 + 24'(3 * batch + i);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    // Pixel 40 (x=0, y=1) is held at idx 1 when reset hits.
    task automatic test_async_reset();
        #1;
        obs = snap(); exp_v = mk(1, 0, 0, 0, 24'h128); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL areset_pre obs=%h exp=%h", obs, exp_v); end
        #1;
        reset = 1'b0;
        #1;
        obs = snap(); exp_v = mk(0, 1, 0, 0, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL areset_immediate obs=%h exp=%h", obs, exp_v); end
        step();
        reset = 1'b1;
        in_data = {24'hCC, 24'hBB, 24'hAA};
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        obs = snap(); exp_v = mk(0, 1, 0, 1, 24'h0); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL areset_capture obs=%h exp=%h", obs, exp_v); end
        step();
        in_valid = 1'b0;
        #1;
        obs = snap(); exp_v = mk(1, 1, 0, 0, 24'hAA); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL areset_sof obs=%h exp=%h", obs, exp_v); end
        step();
        obs = snap(); exp_v = mk(1, 0, 0, 0, 24'hBB); n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL areset_pix1 obs=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_one_batch();
        test_backpressure();
        test_line_straddle();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
